// File: rtl/bar_painter_if.sv
// bar_painter_if: pixel/scanner inputs, buttons and registered RGB of the bar painter.
interface bar_painter_if #(
  parameter int X_BITS = 6,
  parameter int Y_BITS = 6
);
  logic [12:0]       frame;
  logic [7:0]        subframe;
  logic [X_BITS-1:0] x;
  logic [Y_BITS-1:0] y;
  logic [2:0]        buttons;
  logic [2:0]        rgb;
  modport master(output frame, subframe, x, y, buttons, input rgb);
  modport slave(input frame, subframe, x, y, buttons, output rgb);
endinterface

// File: rtl/bar_painter.sv
// bar_painter: scrolling colour bars with button-driven FWD/REV/PAUSE mode and speed.
// Define BAR_PAINTER_DIM_EN to turn BTN3 into a brightness-level button.
module bar_painter #(
  parameter int X_BITS   = 6,
  parameter int Y_BITS   = 6,
  parameter int POS_BITS = 9,
  parameter int PERIOD   = 480,
  parameter int BAR_LEN  = 128,
  parameter int PHASE_R  = 320,
  parameter int PHASE_G  = 160,
  parameter int PHASE_B  = 0
) (
  input logic         clk,
  input logic         reset,
  bar_painter_if.slave bus
);
  typedef enum logic [1:0] {FWD, REV, PAUSE} mode_t;
  localparam logic [POS_BITS:0] PER = (POS_BITS+1)'(PERIOD);
  mode_t               mode, mode_n;
  logic [1:0]          speed, speed_n;
  logic [POS_BITS-1:0] pos, pos_n;
  logic [2:0]          btn_q, press, lit, rgb_n;
  logic [12:0]         prev_frame;
  logic                tick;
  logic [POS_BITS:0]   step, fw, rv, mv, d, u;
  logic [X_BITS-1:0]   xv;
  logic [Y_BITS-1:0]   yv;
  int                  ui;
  logic                unused;
`ifdef BAR_PAINTER_DIM_EN
  logic [2:0]          level, level_n;
`endif
  assign xv = bus.x;
  assign yv = bus.y;
  assign unused = ^{yv, bus.subframe};
  always_comb begin
    tick = bus.frame != prev_frame;
    press = tick ? bus.buttons & ~btn_q : 3'b000;
    step = (POS_BITS+1)'(speed) + (POS_BITS+1)'(1);
    fw = {1'b0, pos} + step;
    rv = {1'b0, pos} - step;
    mv = mode == FWD ? (fw >= PER ? fw - PER : fw) :
         mode == REV ? (rv[POS_BITS] ? rv + PER : rv) : {1'b0, pos};
    pos_n = tick ? mv[POS_BITS-1:0] : pos;
    mode_n = !press[0] ? mode : mode == FWD ? REV : mode == REV ? PAUSE : FWD;
    speed_n = speed + {1'b0, press[1]};
`ifdef BAR_PAINTER_DIM_EN
    level_n = level + {2'b00, press[2]};
`else
    // BTN3 wins over every other press and over the position step
    if (press[2]) begin
      pos_n = '0;
      mode_n = FWD;
      speed_n = '0;
    end
`endif
    d = (POS_BITS+1)'(xv) - {1'b0, pos};
    u = d[POS_BITS] ? d + PER : d;
    ui = int'(u);
    lit = {ui >= PHASE_B && ui < PHASE_B + BAR_LEN,
           ui >= PHASE_G && ui < PHASE_G + BAR_LEN,
           ui >= PHASE_R && ui < PHASE_R + BAR_LEN};
`ifdef BAR_PAINTER_DIM_EN
    rgb_n = bus.subframe[7:5] <= level ? lit : 3'b000;
`else
    rgb_n = lit;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rgb <= '0;
      pos <= '0;
      mode <= FWD;
      speed <= '0;
      btn_q <= '0;
      prev_frame <= '0;
`ifdef BAR_PAINTER_DIM_EN
      level <= 3'd7;
`endif
    end else begin
      bus.rgb <= rgb_n;
      pos <= pos_n;
      mode <= mode_n;
      speed <= speed_n;
      prev_frame <= bus.frame;
      if (tick) btn_q <= bus.buttons;
`ifdef BAR_PAINTER_DIM_EN
      level <= level_n;
`endif
    end
  end
endmodule

// File: tb/tb_bar_painter.sv
// tb_bar_painter: randomized and directed checks of bar_painter against an arithmetic reference model.
module tb_bar_painter;
  localparam int P = 480, BL = 128, PR = 320, PG = 160, PB = 0;
  logic clk = 0, reset = 1;
  int checks = 0, failures = 0;
  int m_pos, m_mode, m_spd, m_lvl;
  bit [2:0] m_bq;
  bit [12:0] m_prev;
  logic [2:0] exp_rgb;
  bar_painter_if #(.X_BITS(6), .Y_BITS(6)) bus();
  bar_painter dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic bit in_bar(int u, int ph);
    return u >= ph && u < ph + BL;
  endfunction

  function automatic bit [2:0] pix(int xv, int p, int sf);
    int u = xv - p;
    if (u < 0) u += P;
`ifdef BAR_PAINTER_DIM_EN
    if ((sf >> 5) > m_lvl) return 3'b000;
`endif
    return {in_bar(u, PB), in_bar(u, PG), in_bar(u, PR)};
  endfunction

  // Advance the model by one clock edge from the currently driven inputs, then step the DUT.
  task automatic cyc;
    bit [2:0] e;
    if (reset) begin
      exp_rgb = 0; m_pos = 0; m_mode = 0; m_spd = 0; m_bq = 0; m_prev = 0; m_lvl = 7;
    end else begin
      exp_rgb = pix(int'(bus.x), m_pos, int'(bus.subframe));
      if (bus.frame != m_prev) begin
        e = bus.buttons & ~m_bq;
        m_bq = bus.buttons;
        if (m_mode == 0) m_pos = (m_pos + m_spd + 1) % P;
        else if (m_mode == 1) m_pos = (m_pos - m_spd - 1 + P) % P;
        if (e[0]) m_mode = (m_mode + 1) % 3;
        if (e[1]) m_spd = (m_spd + 1) % 4;
`ifdef BAR_PAINTER_DIM_EN
        if (e[2]) m_lvl = (m_lvl + 1) % 8;
`else
        if (e[2]) begin m_pos = 0; m_mode = 0; m_spd = 0; end
`endif
      end
      m_prev = bus.frame;
    end
    @(posedge clk); #1;
  endtask

  task automatic tk(input bit [2:0] b);
    bus.buttons = b;
    bus.frame = bus.frame + 13'd1;
    cyc();
  endtask

  task automatic test_reset;
    reset = 1; bus.frame = 0; bus.buttons = 0; bus.x = 0; bus.y = 0; bus.subframe = 0;
    cyc(); cyc();
    checks++; if (bus.rgb !== 3'b000) begin failures++; $display("FAIL reset_rgb got=%b want=000", bus.rgb); end
    reset = 0; bus.x = 0; cyc();
    checks++; if (bus.rgb !== 3'b100 || bus.rgb !== exp_rgb) begin failures++; $display("FAIL reset_x0 got=%b want=100", bus.rgb); end
    bus.x = 60; cyc();
    checks++; if (bus.rgb !== 3'b100) begin failures++; $display("FAIL reset_x60 got=%b want=100", bus.rgb); end
  endtask

  task automatic test_fwd;
    bus.x = 0; tk(0);
    checks++; if (bus.rgb !== 3'b100) begin failures++; $display("FAIL fwd_pre got=%b want=100", bus.rgb); end
    cyc();
    checks++; if (bus.rgb !== 3'b000) begin failures++; $display("FAIL fwd_pos1 got=%b want=000", bus.rgb); end
    for (int i = 0; i < 479; i++) begin
      bus.x = 6'($urandom);
      tk(0);
      checks++; if (bus.rgb !== exp_rgb) begin failures++; $display("FAIL fwd_scan i=%0d got=%b want=%b", i, bus.rgb, exp_rgb); end
    end
    bus.x = 0; cyc();
    checks++; if (bus.rgb !== 3'b100) begin failures++; $display("FAIL fwd_wrap got=%b want=100", bus.rgb); end
  endtask

  task automatic test_rev;
    bus.x = 0;
    tk(1); tk(0); tk(0);
    bus.x = 10; cyc();
    checks++; if (bus.rgb !== 3'b100 || bus.rgb !== exp_rgb) begin failures++; $display("FAIL rev_479 got=%b want=100", bus.rgb); end
  endtask

  task automatic test_speed;
    bit [2:0] seq [16] = '{2, 0, 2, 0, 1, 0, 0, 0, 1, 0, 0, 3, 0, 0, 1, 0};
    for (int i = 0; i < 16; i++) begin
      bus.x = 6'($urandom);
      tk(seq[i]);
      checks++; if (bus.rgb !== exp_rgb) begin failures++; $display("FAIL speed i=%0d got=%b want=%b", i, bus.rgb, exp_rgb); end
      for (int j = 0; j < 3; j++) begin
        bus.x = 6'($urandom); cyc();
        checks++; if (bus.rgb !== exp_rgb) begin failures++; $display("FAIL speed_px i=%0d got=%b want=%b", i, bus.rgb, exp_rgb); end
      end
    end
  endtask

`ifndef BAR_PAINTER_DIM_EN
  task automatic test_btn3;
    bus.x = 0; tk(7); cyc();
    checks++; if (bus.rgb !== 3'b100) begin failures++; $display("FAIL btn3_pos0 got=%b want=100", bus.rgb); end
    tk(0); cyc();
    checks++; if (bus.rgb !== 3'b000 || bus.rgb !== exp_rgb) begin failures++; $display("FAIL btn3_step1 got=%b want=000", bus.rgb); end
  endtask
`else
  task automatic test_dim;
    for (int i = 0; i < 8; i++) tk(i[0] ? 3'b000 : 3'b100);
    while (m_lvl != 0) begin tk(4); tk(0); end
    bus.x = 0;
    for (int i = 0; i < 8; i++) begin
      bus.subframe = i[0] ? 8'h20 : 8'h1F; cyc();
      checks++; if (bus.rgb !== exp_rgb) begin failures++; $display("FAIL dim i=%0d got=%b want=%b", i, bus.rgb, exp_rgb); end
    end
    for (int i = 0; i < 16; i++) begin
      bus.subframe = 8'($urandom); bus.x = 6'($urandom); tk(i[0] ? 3'b000 : 3'b100);
      checks++; if (bus.rgb !== exp_rgb) begin failures++; $display("FAIL dim_lvl i=%0d got=%b want=%b", i, bus.rgb, exp_rgb); end
    end
    bus.subframe = 0;
  endtask
`endif

  task automatic test_held;
    for (int i = 0; i < 24; i++) begin
      bus.x = 6'($urandom);
      tk(i < 20 ? 3'b010 : 3'b000);
      checks++; if (bus.rgb !== exp_rgb) begin failures++; $display("FAIL held i=%0d got=%b want=%b", i, bus.rgb, exp_rgb); end
    end
  endtask

  task automatic test_tick_after_reset;
    reset = 1; bus.frame = 5; bus.buttons = 0; bus.x = 0; bus.subframe = 0;
    cyc(); reset = 0; cyc();
    checks++; if (bus.rgb !== 3'b100) begin failures++; $display("FAIL tar_first got=%b want=100", bus.rgb); end
    cyc();
    checks++; if (bus.rgb !== 3'b000 || bus.rgb !== exp_rgb) begin failures++; $display("FAIL tar_pos1 got=%b want=000", bus.rgb); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 199) == 0;
      if ($urandom_range(0, 2) == 0) bus.frame = bus.frame + 13'd1;
      if ($urandom_range(0, 5) == 0) bus.buttons = 3'($urandom);
      bus.x = 6'($urandom); bus.y = 6'($urandom); bus.subframe = 8'($urandom);
      cyc();
      checks++; if (bus.rgb !== exp_rgb) begin failures++; $display("FAIL random i=%0d got=%b want=%b", i, bus.rgb, exp_rgb); end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_fwd();
    test_rev();
    test_speed();
`ifndef BAR_PAINTER_DIM_EN
    test_btn3();
`else
    test_dim();
`endif
    test_held();
    test_tick_after_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
